// File: rtl/tdc_meas_ctrl_if.sv
// rtl/tdc_meas_ctrl_if.sv - result stream bundle between tdc_meas_ctrl and its readout consumer
interface tdc_meas_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_coarse;
  logic [3:0]            res_idx;
  logic                  res_timeout;

  modport master (
    output res_valid,
    output res_coarse,
    output res_idx,
    output res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_coarse,
    input  res_idx,
    input  res_timeout,
    output res_ready
  );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - TDC coarse-path measurement sequencer (arm/start/stop to clr/latch/result)
// Define TDC_CTRL_TIMEOUT_EN to build the RUN timeout counter and the TOUT record path.
module tdc_meas_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_STOPS      = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  start_hit,
  input  logic                  stop_hit,
  input  logic [DATA_WIDTH-1:0] coarse_time,
  output logic                  cnt_clr,
  output logic                  cnt_latch,
  output logic                  busy,
  output logic                  drop_err,
  tdc_meas_ctrl_if.master       res
);
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_TOUT} state_t;

  localparam logic [3:0] LAST_STOP = 4'(MAX_STOPS - 1);

  if (MAX_STOPS < 1 || MAX_STOPS > 15 || TIMEOUT_CYCLES < 4) begin : g_param_check
    $error("tdc_meas_ctrl: parameter out of range");
  end

  state_t                state;
  logic [3:0]            stop_cnt;
  logic [3:0]            lat_idx;
  logic                  cap_v;
  logic [3:0]            cap_idx;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_coarse;
  logic [3:0]            out_idx;
  logic                  out_free;

`ifdef TDC_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;
  logic          out_timeout;
  assign res.res_timeout = out_timeout;
`else
  assign res.res_timeout = 1'b0;
`endif

  assign out_free       = !out_valid || res.res_ready;
  assign res.res_valid  = out_valid;
  assign res.res_coarse = out_coarse;
  assign res.res_idx    = out_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      cnt_clr    <= 1'b0;
      cnt_latch  <= 1'b0;
      drop_err   <= 1'b0;
      stop_cnt   <= 4'd0;
      lat_idx    <= 4'd0;
      cap_v      <= 1'b0;
      cap_idx    <= 4'd0;
      out_valid  <= 1'b0;
      out_coarse <= '0;
      out_idx    <= 4'd0;
`ifdef TDC_CTRL_TIMEOUT_EN
      tcnt        <= '0;
      out_timeout <= 1'b0;
`endif
    end else begin
      cnt_clr   <= 1'b0;
      cnt_latch <= 1'b0;
      cap_v     <= cnt_latch;
      cap_idx   <= lat_idx;

      if (out_valid && res.res_ready) out_valid <= 1'b0;

      // The counter holds the value one cycle short of the stop, hence +1.
      if (cap_v) begin
        if (out_free) begin
          out_valid  <= 1'b1;
          out_coarse <= coarse_time + DATA_WIDTH'(1);
          out_idx    <= cap_idx;
`ifdef TDC_CTRL_TIMEOUT_EN
          out_timeout <= 1'b0;
`endif
        end else begin
          drop_err <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (arm) begin
            state <= S_ARMED;
            busy  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (start_hit) begin
            state    <= S_RUN;
            cnt_clr  <= 1'b1;
            stop_cnt <= 4'd0;
`ifdef TDC_CTRL_TIMEOUT_EN
            tcnt <= '0;
`endif
          end
        end
        S_RUN: begin
          if (stop_hit) begin
            cnt_latch <= 1'b1;
            lat_idx   <= stop_cnt;
            stop_cnt  <= stop_cnt + 4'd1;
            if (stop_cnt == LAST_STOP) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
`ifdef TDC_CTRL_TIMEOUT_EN
          // Saturating count: a stop on the expiry cycle defers expiry by one cycle.
          else if (tcnt == TOUT_LAST) begin
            state <= S_TOUT;
          end
          if (tcnt != TOUT_LAST) tcnt <= tcnt + TW'(1);
`endif
        end
`ifdef TDC_CTRL_TIMEOUT_EN
        S_TOUT: begin
          if (!cnt_latch && !cap_v && out_free) begin
            out_valid   <= 1'b1;
            out_coarse  <= '0;
            out_idx     <= stop_cnt;
            out_timeout <= 1'b1;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the TDC coarse path. Arms on request, converts synchronized start/stop hit pulses into `clr`/`latch` strobes for the coarse counter, captures the latched `coarse_time`, and emits one result per stop through a valid/ready port. Sits between the hit synchronizers and the readout logic; one instance drives one coarse counter.

## Interface
- `DATA_WIDTH`, 32, coarse count width; must match the coarse counter.
- `MAX_STOPS`, 4, stops accepted per measurement (1..15).
- `TIMEOUT_CYCLES`, 1000, RUN-state limit counted from the start hit (≥ 4).

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  one-cycle request to arm; honoured only in IDLE.
- `start_hit`  in  1  synchronized single-cycle start pulse.
- `stop_hit`  in  1  synchronized single-cycle stop pulse.
- `coarse_time`  in  DATA_WIDTH  latched value from the coarse counter.
- `cnt_clr`  out  1  registered clear strobe to the counter.
- `cnt_latch`  out  1  registered latch strobe to the counter.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result when `res_valid && res_ready`.
- `res_coarse`  out  DATA_WIDTH  start-to-stop distance in clk cycles.
- `res_idx`  out  4  stop index (0-based), or stops taken for a timeout record.
- `res_timeout`  out  1  result is a timeout record.
- `busy`  out  1  state is not IDLE.
- `drop_err`  out  1  sticky: a result was lost to a full output register. Cleared only by `rst`.

## Operation
- States: IDLE, ARMED, RUN, TOUT.
- IDLE: `arm` → ARMED. `start_hit` and `stop_hit` are ignored.
- ARMED: `start_hit` → RUN. Assert `cnt_clr` next cycle. Clear the stop count and timeout counter. `stop_hit` in ARMED is ignored, including when it coincides with start.
- RUN, per `stop_hit`:
  - Assert `cnt_latch` next cycle and increment the stop count.
  - When the count reaches `MAX_STOPS` → IDLE. The in-flight capture still completes.
  - `start_hit` in RUN is ignored.
- Capture stage: one cycle after `cnt_latch`, sample `coarse_time`.
  - Result: `res_coarse = coarse_time + 1` (mod 2^DATA_WIDTH), with the stop's `res_idx` and `res_timeout = 0`.
  - If the output register is valid and not accepted in that cycle, discard the result and set `drop_err`. Otherwise load it.
- Timeout (macro enabled): the timeout counter runs in RUN.
  - When it reaches `TIMEOUT_CYCLES` with count < `MAX_STOPS` → TOUT.
  - TOUT waits until the output register is free or being accepted, then loads `res_timeout = 1`, `res_coarse = 0`, `res_idx` = stops taken, and goes → IDLE. A timeout record is never dropped.
  - A stop in the same cycle as expiry is accepted and expiry is re-evaluated next cycle. If that stop was the last one, the measurement ends normally.
  - Pending stop captures complete before the timeout record is loaded.
- Output register: holds until accepted. Fields are stable while `res_valid && !res_ready`.
- `arm` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `rst` mid-measurement:
  - Abandons the measurement and any in-flight capture.
  - No `cnt_clr` or `cnt_latch` is issued in the cycle after reset.
  - Clears `res_valid`.
- Start at cycle t → `cnt_clr` at t+1 → counter is 0 at t+2.
- Stop at cycle s → `cnt_latch` at s+1 → capture at s+2 → `res_valid` at s+3.
- Required result: `res_coarse = s − t`.
- Stops may arrive on consecutive cycles. The latch/capture pipeline accepts one per cycle; results are lost only through output backpressure.
- Wrap: a distance ≥ 2^DATA_WIDTH aliases modulo 2^DATA_WIDTH. No flag is raised.
- `busy` rises the cycle after the accepted `arm` and falls the cycle after the IDLE transition.

## Configuration
- `TDC_CTRL_TIMEOUT_EN`
  - Defined: timeout counter and TOUT state are present, as described above.
  - Undefined: no timeout logic. RUN exits only after `MAX_STOPS` stops or on `rst`. `res_timeout` is tied 0.

## Test plan
- Arm, start at t=10, stop at t=25, `res_ready` = 1 → `cnt_clr` at 11, `cnt_latch` at 26, `res_valid` at 28 with `res_coarse` = 15, `res_idx` = 0; IDLE after.
- `MAX_STOPS` = 4, stops on 4 consecutive cycles 5–8 after start, ready high → 4 results with coarse 5, 6, 7, 8 and idx 0–3; `drop_err` = 0; back to IDLE.
- `res_ready` = 0, two stops 3 cycles apart → first result held stable, second dropped, `drop_err` = 1 until `rst`.
- Timeout enabled, `TIMEOUT_CYCLES` = 20, one stop then silence → result idx 0, then timeout record with `res_timeout` = 1, `res_idx` = 1, `res_coarse` = 0; IDLE.
- Start and stop in the same ARMED cycle; `start_hit` during RUN; `arm` during RUN → stop ignored, no second `cnt_clr`, state unaffected.
- `rst` asserted the cycle after a stop → no `cnt_latch` or result; all outputs 0; a new `arm`/start/stop measures correctly.
